// File: rtl/sort_ctrl_if.sv
// sort_ctrl_if -- bus bundle for sort_ctrl.
//   master: drives START / WR_EN / WR_ADDR / WR_DATA / RD_ADDR,
//           observes RD_DATA / BUSY / SORTED_CLR / LD.
//   slave : the sorter side of the same signals.
// Parameters N (entries) and W (entry width) must match the sort_ctrl instance.
interface sort_ctrl_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int AW = $clog2(N);

  logic          START;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [W-1:0]  WR_DATA;
  logic [AW-1:0] RD_ADDR;
  logic [W-1:0]  RD_DATA;
  logic          BUSY;
  logic          SORTED_CLR;
  logic          LD;

  modport master (
    output START, WR_EN, WR_ADDR, WR_DATA, RD_ADDR,
    input  RD_DATA, BUSY, SORTED_CLR, LD
  );

  modport slave (
    input  START, WR_EN, WR_ADDR, WR_DATA, RD_ADDR,
    output RD_DATA, BUSY, SORTED_CLR, LD
  );
endinterface

// File: rtl/sort_ctrl.sv
// sort_ctrl -- in-place ascending bubble sort over an N x W register array.
// Ports:
//   CLK        sole clock, rising edge
//   RST_N      asynchronous active-low reset (clears FSM and array)
//   bus.slave  START, WR_EN/WR_ADDR/WR_DATA (load, IDLE only),
//              RD_ADDR -> RD_DATA (combinational read),
//              BUSY (not IDLE), SORTED_CLR (CLEAR state), LD (FINISH state)
// Each pass is N-1 SCAN cycles plus one CHECK cycle; a pass with no swap ends
// the sort, so latency from START is 1 + passes*N + 1 cycles to LD.
module sort_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input logic       CLK,
  input logic       RST_N,
  sort_ctrl_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_I = AW'(N - 2);
  localparam logic [AW:0]   N_L    = (AW + 1)'(N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    CHECK,
    FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [N];
  logic [AW-1:0] i;
  logic [AW-1:0] ip1;
  logic          swapped;
  logic          wr_ok;
  logic          do_swap;

  assign ip1     = i + 1'b1;
  assign wr_ok   = bus.WR_EN && ({1'b0, bus.WR_ADDR} < N_L);
  // Strict compare: equal neighbours stay put, so duplicates cannot keep a pass dirty.
  assign do_swap = mem[i] > mem[ip1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      i       <= '0;
      swapped <= 1'b0;
      for (int unsigned k = 0; k < N; k++) mem[k] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wr_ok) mem[bus.WR_ADDR] <= bus.WR_DATA;
        end
        CLEAR: begin
          i       <= '0;
          swapped <= 1'b0;
        end
        SCAN: begin
          if (do_swap) begin
            mem[i]   <= mem[ip1];
            mem[ip1] <= mem[i];
            swapped  <= 1'b1;
          end
          i <= ip1;
        end
        CHECK: begin
          if (swapped) begin
            swapped <= 1'b0;
            i       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = CLEAR;
      CLEAR:   state_nxt = SCAN;
      SCAN:    if (i == LAST_I) state_nxt = CHECK;
      CHECK:   state_nxt = swapped ? SCAN : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.BUSY       = (state != IDLE);
  assign bus.SORTED_CLR = (state == CLEAR);
  assign bus.LD         = (state == FINISH);
  assign bus.RD_DATA    = ({1'b0, bus.RD_ADDR} < N_L) ? mem[bus.RD_ADDR] : '0;
endmodule

// File: tb/tb_sort_ctrl.sv
module tb_sort_ctrl;
  localparam int N = 8;
  localparam int W = 8;
  typedef logic [W-1:0] arr_t [N];

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  sort_ctrl_if #(.N(N), .W(W)) bus ();
  sort_ctrl #(.N(N), .W(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  task automatic load_array(input arr_t a);
    for (int k = 0; k < N; k++) begin
      bus.WR_EN = 1'b1; bus.WR_ADDR = 3'(k); bus.WR_DATA = a[k];
      @(posedge CLK); #1;
    end
    bus.WR_EN = 1'b0;
  endtask

  // Pulses START (plus whatever WR_* the caller set up) and follows the sort
  // until LD, with a cycle budget. Returns to IDLE before returning.
  task automatic run_sort(input bit disturb, output int lat, output int clr_at,
                          output int clr_n, output int ld_n, output int both);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.WR_EN = 1'b0;
    lat = 1; clr_at = -1; clr_n = 0; ld_n = 0; both = 0;
    while (1) begin
      if (bus.SORTED_CLR) begin clr_n++; if (clr_at < 0) clr_at = lat; end
      if (bus.LD) ld_n++;
      if (bus.SORTED_CLR && bus.LD) both++;
      if (bus.LD || lat >= 300) break;
      if (disturb) begin
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'(lat); bus.WR_DATA = 8'hAA;
        bus.START = lat[0];
      end
      @(posedge CLK); #1;
      lat++;
    end
    bus.WR_EN = 1'b0; bus.START = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    bus.START = 0; bus.WR_EN = 0; bus.WR_ADDR = 0; bus.WR_DATA = 0; bus.RD_ADDR = 0;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.SORTED_CLR !== 1'b0) begin failures++; $display("FAIL reset_clr got %b exp 0", bus.SORTED_CLR); end
    checks++; if (bus.LD !== 1'b0) begin failures++; $display("FAIL reset_ld got %b exp 0", bus.LD); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++;
      if (bus.RD_DATA !== 8'd0) begin failures++; $display("FAIL reset_rd[%0d] got %0d exp 0", k, bus.RD_DATA); end
    end
    @(posedge CLK); @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %b exp 0", bus.BUSY); end
  endtask

  task automatic test_presorted;
    arr_t a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    int lat, clr_at, clr_n, ld_n, both;
    load_array(a);
    run_sort(1'b0, lat, clr_at, clr_n, ld_n, both);
    checks++; if (lat !== 10) begin failures++; $display("FAIL presorted_latency got %0d exp 10", lat); end
    checks++; if (clr_at !== 1) begin failures++; $display("FAIL presorted_clr_cycle got %0d exp 1", clr_at); end
    checks++; if (clr_n !== 1 || ld_n !== 1) begin failures++; $display("FAIL presorted_pulses got clr=%0d ld=%0d exp 1/1", clr_n, ld_n); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL presorted_idle got %b exp 0", bus.BUSY); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== a[k]) begin failures++; $display("FAIL presorted_rd[%0d] got %0d exp %0d", k, bus.RD_DATA, a[k]); end
    end
  endtask

  task automatic test_reverse;
    arr_t a = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    arr_t e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    int lat, clr_at, clr_n, ld_n, both;
    load_array(a);
    run_sort(1'b0, lat, clr_at, clr_n, ld_n, both);
    checks++; if (lat !== 66) begin failures++; $display("FAIL reverse_latency got %0d exp 66", lat); end
    checks++; if (clr_n !== 1 || ld_n !== 1) begin failures++; $display("FAIL reverse_pulses got clr=%0d ld=%0d exp 1/1", clr_n, ld_n); end
    checks++; if (both !== 0) begin failures++; $display("FAIL reverse_overlap got %0d exp 0", both); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== e[k]) begin failures++; $display("FAIL reverse_rd[%0d] got %0d exp %0d", k, bus.RD_DATA, e[k]); end
    end
  endtask

  task automatic test_duplicates;
    arr_t a = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd5};
    arr_t e = '{8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255};
    int lat, clr_at, clr_n, ld_n, both;
    load_array(a);
    run_sort(1'b0, lat, clr_at, clr_n, ld_n, both);
    // five passes (four with swaps, one clean): 1 + 5*8 + 1
    checks++; if (lat !== 42) begin failures++; $display("FAIL dup_latency got %0d exp 42", lat); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== e[k]) begin failures++; $display("FAIL dup_rd[%0d] got %0d exp %0d", k, bus.RD_DATA, e[k]); end
    end
  endtask

  task automatic test_write_with_start;
    arr_t a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    arr_t e = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd200};
    int lat, clr_at, clr_n, ld_n, both;
    load_array(a);
    bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd0; bus.WR_DATA = 8'd200;
    run_sort(1'b0, lat, clr_at, clr_n, ld_n, both);
    checks++; if (lat !== 18) begin failures++; $display("FAIL wr_start_latency got %0d exp 18", lat); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== e[k]) begin failures++; $display("FAIL wr_start_rd[%0d] got %0d exp %0d", k, bus.RD_DATA, e[k]); end
    end
  endtask

  task automatic test_busy_ignore;
    arr_t a = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    arr_t e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    int lat, clr_at, clr_n, ld_n, both;
    load_array(a);
    run_sort(1'b1, lat, clr_at, clr_n, ld_n, both);
    checks++; if (lat !== 66) begin failures++; $display("FAIL busy_latency got %0d exp 66", lat); end
    checks++; if (clr_n !== 1 || ld_n !== 1) begin failures++; $display("FAIL busy_pulses got clr=%0d ld=%0d exp 1/1", clr_n, ld_n); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== e[k]) begin failures++; $display("FAIL busy_rd[%0d] got %0d exp %0d", k, bus.RD_DATA, e[k]); end
    end
  endtask

  task automatic test_abort;
    arr_t a = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    int cyc;
    int ld_seen;
    load_array(a);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    cyc = 1;
    while (cyc < 20) begin @(posedge CLK); #1; cyc++; end
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b exp 1", bus.BUSY); end
    RST_N = 1'b0;
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.LD !== 1'b0 || bus.SORTED_CLR !== 1'b0) begin failures++; $display("FAIL abort_strobes got ld=%b clr=%b exp 0/0", bus.LD, bus.SORTED_CLR); end
    for (int k = 0; k < N; k++) begin
      bus.RD_ADDR = 3'(k); #1;
      checks++; if (bus.RD_DATA !== 8'd0) begin failures++; $display("FAIL abort_rd[%0d] got %0d exp 0", k, bus.RD_DATA); end
    end
    @(negedge CLK); RST_N = 1'b1;
    bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd3; bus.WR_DATA = 8'h5A;
    @(posedge CLK); #1;
    bus.WR_EN = 1'b0; bus.RD_ADDR = 3'd3; #1;
    checks++; if (bus.RD_DATA !== 8'h5A) begin failures++; $display("FAIL first_edge_write got %0h exp 5a", bus.RD_DATA); end
    ld_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge CLK); #1;
      if (bus.LD) ld_seen++;
    end
    checks++; if (ld_seen !== 0) begin failures++; $display("FAIL abort_no_ld got %0d exp 0", ld_seen); end
  endtask

  initial begin
    test_reset;
    test_presorted;
    test_reverse;
    test_duplicates;
    test_write_with_start;
    test_busy_ignore;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, number of entries (N >= 2).
REQ-002 The block SHALL have parameter W, default 8, entry width in bits.
REQ-003 The block SHALL have derived parameter AW, equal to clog2(N), the address width.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  request to sort the array; sampled only in IDLE.
REQ-007 WR_EN  input  1  write strobe for loading the array; sampled only in IDLE.
REQ-008 WR_ADDR  input  AW  write index.
REQ-009 WR_DATA  input  W  write value.
REQ-010 RD_ADDR  input  AW  read index.
REQ-011 RD_DATA  output  W  array entry at RD_ADDR, combinational read.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 SORTED_CLR  output  1  clear strobe to the downstream sorted-flag register.
REQ-014 LD  output  1  load strobe to the downstream sorted-flag register; marks sort complete.

Function
REQ-015 The block SHALL hold an internal array of N registers of W bits each.
REQ-016 The FSM SHALL have states IDLE, CLEAR, SCAN, CHECK and FINISH.
REQ-017 In IDLE, when WR_EN=1 and WR_ADDR<N, the block SHALL write WR_DATA to entry WR_ADDR at the clock edge.
REQ-018 The block SHALL ignore writes with WR_ADDR>=N.
REQ-019 In IDLE, START=1 SHALL move the FSM to CLEAR.
REQ-020 When WR_EN and START are both high in the same IDLE cycle, the write SHALL commit and the sort SHALL use the new value.
REQ-021 CLEAR SHALL last 1 cycle, with SORTED_CLR=1, index i=0 and swap flag cleared, then move to SCAN.
REQ-022 Each SCAN cycle SHALL compare entry i with entry i+1, unsigned.
REQ-023 In SCAN, when entry i > entry i+1, the block SHALL swap both entries at the edge and set the swap flag.
REQ-024 In SCAN, equal entries SHALL NOT be swapped.
REQ-025 In SCAN, i SHALL increment each cycle; after the compare at i=N-2, the FSM SHALL move to CHECK.
REQ-026 In CHECK (1 cycle), when the swap flag is set, the block SHALL clear the flag, set i=0 and return to SCAN.
REQ-027 In CHECK, when the swap flag is clear, the FSM SHALL move to FINISH.
REQ-028 FINISH SHALL last 1 cycle with LD=1, then return to IDLE.
REQ-029 SORTED_CLR and LD SHALL be Moore outputs decoded from state, each high for exactly 1 cycle per sort.
REQ-030 SORTED_CLR and LD SHALL never be high in the same cycle.
REQ-031 While BUSY=1, the block SHALL ignore START and WR_EN with no side effects.
REQ-032 The result order SHALL be ascending: entry 0 is the smallest.
REQ-033 Sort latency SHALL be 1 + P*N + 1 cycles from START sampled to the LD cycle, where P is the number of passes (1..N), including the final swap-free pass.
REQ-034 RD_DATA SHALL reflect intermediate contents during a sort; it is valid as the result only once BUSY=0.

Reset
REQ-035 RST_N=0 SHALL, asynchronously, force state IDLE, i=0, swap flag=0 and every array entry=0.
REQ-036 During reset, outputs SHALL be BUSY=0, SORTED_CLR=0, LD=0 and RD_DATA=0.
REQ-037 Reset asserted mid-sort SHALL abort the sort with no LD pulse, and the array SHALL read 0 after reset.
REQ-038 After RST_N deasserts, the block SHALL accept START or WR_EN on the first rising edge.

Verification
REQ-039 Reset, then read all addresses -> RD_DATA=0 for every entry; BUSY=0, LD=0, SORTED_CLR=0.
REQ-040 Load 1..8 (already sorted), then START -> SORTED_CLR in cycle 1, LD in cycle 10, array unchanged.
REQ-041 Load 8,7,6,5,4,3,2,1, then START -> LD in cycle 66; array reads 1..8; exactly one SORTED_CLR and one LD pulse.
REQ-042 Load 5,5,0,255,5,0,255,5, then START -> result 0,0,5,5,5,5,255,255; terminates with no swap of equal entries.
REQ-043 During BUSY, drive WR_EN with a value and pulse START -> array and latency identical to an undisturbed run.
REQ-044 Assert RST_N=0 in the 20th cycle of a reverse-order sort -> immediate IDLE, no LD pulse, all entries read 0.
